// File: rtl/toothless_pkg.sv
// toothless_pkg: shared fetch entry type and fetch constants
package toothless_pkg;
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push, pop, flush, occupancy and registered head
// ports: clk, rst_n (sync active-low), push/din, pop, flush (wins over push/pop), dout/valid head, count occupancy
module fetch_fifo import toothless_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  fetch_entry_t    din,
  input  logic            pop,
  input  logic            flush,
  output fetch_entry_t    dout,
  output logic            valid,
  output logic [CW-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic take;
  assign take = pop && valid;
  assign valid = count != '0;
  // head reads straight from the storage flops and is zeroed when empty
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (take) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(take);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front-end with req/gnt/rvalid memory port, entry FIFO and redirect flush
// ports: clk, rst_n (sync active-low); instr_req_o/instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i memory side;
// instr_valid_o/instr_o/instr_pc_o/instr_fault_o/instr_ready_i decoder side; redirect_i/redirect_addr_i control transfer.
// FETCH_ALIGN_CHECK_EN: misaligned redirect pushes a faulting NOP and stalls fetch until the next redirect.
module fetch_stage import toothless_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   instr_req_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  output logic                   instr_fault_o,
  input  logic                   instr_ready_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] fetch_pc, rsp_pc, pc_base, tgt, flt_pc;
  logic [CW-1:0] outst, drop, occ, outst_n, occ_n;
  logic hold, gnt_acc, launch, take, push, pop, stall_n, flt_q;
  fetch_entry_t din, head;
  assign tgt = {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign gnt_acc = instr_req_o && instr_gnt_i;
  assign hold = instr_req_o && !instr_gnt_i;
  assign pop = instr_valid_o && instr_ready_i && !redirect_i;
  assign take = instr_rvalid_i && drop == '0 && !redirect_i;
  assign push = take || flt_q;
  assign din = flt_q ? fetch_entry_t'{instr: NOP_INSTR, pc: flt_pc, fault: 1'b1}
                     : fetch_entry_t'{instr: instr_rdata_i, pc: rsp_pc, fault: 1'b0};
  assign outst_n = outst + CW'(gnt_acc) - CW'(instr_rvalid_i);
  assign occ_n = redirect_i ? '0 : occ + CW'(push) - CW'(pop);
  assign pc_base = redirect_i ? tgt : fetch_pc;
  // credit is judged on next-cycle occupancy plus outstanding, so a granted request always has a free slot
  assign launch = !hold && !stall_n && ({1'b0, occ_n} + {1'b0, outst_n} < LIMIT);
  assign instr_o = head.instr;
  assign instr_pc_o = head.pc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_req_o <= 1'b0;
      instr_addr_o <= BOOT_ADDR;
      fetch_pc <= BOOT_ADDR;
      rsp_pc <= BOOT_ADDR;
      outst <= '0;
      drop <= '0;
    end else begin
      instr_req_o <= hold || launch;
      instr_addr_o <= hold ? instr_addr_o : pc_base;
      fetch_pc <= launch ? pc_base + ADDR_WIDTH'(4) : pc_base;
      rsp_pc <= redirect_i ? tgt : take ? rsp_pc + ADDR_WIDTH'(4) : rsp_pc;
      outst <= outst_n;
      // a still-ungranted request will be granted later at its old address, so its response is dropped too
      drop <= redirect_i ? outst_n + CW'(hold) : (instr_rvalid_i && drop != '0) ? drop - 1'b1 : drop;
    end
  end
`ifdef FETCH_ALIGN_CHECK_EN
  logic stall_q, mis;
  assign mis = redirect_i && redirect_addr_i[1:0] != 2'b00;
  assign stall_n = redirect_i ? mis : stall_q;
  assign instr_fault_o = head.fault;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      flt_q <= 1'b0;
      flt_pc <= '0;
    end else begin
      stall_q <= stall_n;
      flt_q <= mis;
      flt_pc <= redirect_addr_i;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{head.fault, redirect_addr_i[1:0]};
  assign stall_n = 1'b0;
  assign flt_q = 1'b0;
  assign flt_pc = '0;
  assign instr_fault_o = 1'b0;
`endif
  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(din),
    .pop(pop),
    .flush(redirect_i),
    .dout(head),
    .valid(instr_valid_o),
    .count(occ)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table-driven and sequence checks of fetch_stage against a pipelined memory model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i, instr_o, instr_pc_o, redirect_addr_i;
  logic instr_valid_o, instr_fault_o;
  logic instr_ready_i = 1'b1;
  logic redirect_i = 1'b0;
  logic gnt_en = 1'b1;
  int lat = 1;
  int checks = 0;
  int errors = 0;
  logic pv [4];
  logic [31:0] pa [4];

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs [10];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_fault_o(instr_fault_o), .instr_ready_i(instr_ready_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign instr_gnt_i = gnt_en && instr_req_o;
  assign instr_rvalid_i = pv[lat-1];
  assign instr_rdata_i = pv[lat-1] ? mem_word(pa[lat-1]) : 32'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= instr_req_o && instr_gnt_i;
      pa[0] <= instr_addr_o;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual %h required %h", n, a, e);
    end
  endtask

  task automatic reset_dut(input int cycles);
    rst_n = 1'b0;
    redirect_i = 1'b0;
    repeat (cycles) tick;
    chk("rst_req", instr_req_o, 0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_fault", instr_fault_o, 0);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic wait_valid(input string n);
    int k = 0;
    while (!instr_valid_o && k < 40) begin
      tick;
      k++;
    end
    chk(n, k < 40, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int g, n;
    vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[6] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    vecs[7] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[8] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    vecs[9] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    lat = 1;
    instr_ready_i = 1'b1;
    reset_dut(2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("v%0d_req", i), instr_req_o, vecs[i].req);
      chk($sformatf("v%0d_addr", i), instr_addr_o, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), instr_valid_o, vecs[i].valid);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pc", i), instr_pc_o, vecs[i].pc);
        chk($sformatf("v%0d_instr", i), instr_o, mem_word(vecs[i].pc));
      end
      instr_ready_i = vecs[i].ready;
      tick;
    end

    instr_ready_i = 1'b0;
    reset_dut(2);
    g = 0;
    repeat (8) begin
      if (instr_req_o && instr_gnt_i) g++;
      tick;
    end
    chk("full_grants", g, 4);
    chk("full_req", instr_req_o, 0);
    chk("full_valid", instr_valid_o, 1);
    instr_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_pc", k), instr_pc_o, 32'(4 * k));
      chk($sformatf("drain%0d_instr", k), instr_o, mem_word(32'(4 * k)));
      if (k == 1) begin
        chk("resume_req", instr_req_o, 1);
        chk("resume_addr", instr_addr_o, 32'h10);
      end
      tick;
    end

    lat = 4;
    instr_ready_i = 1'b1;
    reset_dut(2);
    repeat (3) tick;
    chk("r3_req", instr_req_o, 1);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h100;
    tick;
    redirect_i = 1'b0;
    chk("r3_valid_off", instr_valid_o, 0);
    wait_valid("r3_wait");
    chk("r3_pc", instr_pc_o, 32'h100);
    chk("r3_instr", instr_o, mem_word(32'h100));

    lat = 1;
    gnt_en = 1'b1;
    reset_dut(2);
    n = 0;
    while (instr_addr_o !== 32'h20 && n < 20) begin
      tick;
      n++;
    end
    chk("r4_reach", n < 20, 1);
    gnt_en = 1'b0;
    redirect_i = 1'b1;
    redirect_addr_i = 32'h40;
    tick;
    redirect_i = 1'b0;
    chk("r4_hold_req", instr_req_o, 1);
    chk("r4_hold_addr", instr_addr_o, 32'h20);
    chk("r4_valid_off", instr_valid_o, 0);
    tick;
    chk("r4_hold_addr2", instr_addr_o, 32'h20);
    gnt_en = 1'b1;
    tick;
    chk("r4_new_req", instr_req_o, 1);
    chk("r4_new_addr", instr_addr_o, 32'h40);
    wait_valid("r4_wait");
    chk("r4_pc", instr_pc_o, 32'h40);
    chk("r4_instr", instr_o, mem_word(32'h40));

`ifdef FETCH_ALIGN_CHECK_EN
    reset_dut(2);
    repeat (4) tick;
    instr_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_addr_i = 32'h102;
    tick;
    redirect_i = 1'b0;
    chk("al_req", instr_req_o, 0);
    chk("al_valid_off", instr_valid_o, 0);
    tick;
    chk("al_valid", instr_valid_o, 1);
    chk("al_pc", instr_pc_o, 32'h102);
    chk("al_fault", instr_fault_o, 1);
    chk("al_instr", instr_o, 32'h13);
    g = 0;
    repeat (5) begin
      if (instr_req_o) g++;
      tick;
    end
    chk("al_noreq", g, 0);
    instr_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_addr_i = 32'h200;
    tick;
    redirect_i = 1'b0;
    wait_valid("al_wait");
    chk("al_rec_pc", instr_pc_o, 32'h200);
    chk("al_rec_fault", instr_fault_o, 0);
    chk("al_rec_instr", instr_o, mem_word(32'h200));
`endif

    lat = 3;
    instr_ready_i = 1'b1;
    reset_dut(2);
    repeat (6) tick;
    chk("mid_req", instr_req_o, 1);
    reset_dut(1);
    chk("mid_restart_req", instr_req_o, 1);
    chk("mid_restart_addr", instr_addr_o, 32'h0);
    wait_valid("mid_wait");
    chk("mid_pc", instr_pc_o, 32'h0);
    chk("mid_instr", instr_o, mem_word(32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
